// File: rtl/rr_mux4_1.sv
// rr_mux4_1: four-channel round-robin merge into one registered stream.
// Each output word is tagged with the index of the channel it came from.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid[3:0]         per-channel valid
//   in_data0..in_data3    per-channel data
//   in_ready[3:0]         per-channel ready (combinational)
//   out_valid, out_data   registered output word
//   out_sel               source channel of out_data
//   out_ready             downstream accept
module rr_mux4_1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  input  logic             out_ready
);

  logic [1:0]       ptr;
  logic [3:0]       grant;
  logic [1:0]       gidx;
  logic [1:0]       idx;
  logic             found;
  logic             load_en;
  logic             accept;
  logic [WIDTH-1:0] gdata;

  // Output slot is free, or is being drained this same cycle.
  assign load_en = rst_n & (~out_valid | out_ready);

  // Scan from ptr upward (mod 4); first valid channel wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && in_valid[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        found      = 1'b1;
      end
    end
  end

  assign in_ready = grant & {4{load_en}};
  assign accept   = load_en & found;

  always_comb begin
    gdata = '0;
    unique case (gidx)
      2'd0: gdata = in_data0;
      2'd1: gdata = in_data1;
      2'd2: gdata = in_data2;
      2'd3: gdata = in_data3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= gdata;
      out_sel   <= gidx;
      // Winner drops to lowest priority next round.
      ptr       <= gidx + 2'd1;
    end else if (out_ready) begin
      // Word consumed with nothing to replace it; data/sel hold.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/rr_mux4_1.md
# rr_mux4_1

Four-to-one round-robin merge stage: collects words from four independent valid/ready source channels and emits them on a single registered output stream tagged with a 2-bit source index. It is the merge end of the 1:4 demux path: out_sel carries the channel number so a downstream demux can steer responses back to the originating channel. Arbitration is fair round-robin with one output register stage, sustaining one word per cycle.

## Interface
- WIDTH, 8, data width of every channel and of the output
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  synchronous, active-low reset, sampled on the clk rising edge
- in_valid  input  4  per-channel valid; bit i belongs to channel i
- in_data0..in_data3  input  WIDTH each  channel i data, meaningful when in_valid[i]=1
- in_ready  output  4  per-channel ready; a transfer occurs on channel i when in_valid[i] and in_ready[i] are both 1 at a clk edge
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  registered data word
- out_sel  output  2  registered index of the source channel of out_data
- out_ready  input  1  downstream accepts out_data when out_valid=1 and out_ready=1

## Operation
- Internal state: output register (out_valid, out_data, out_sel) and a 2-bit round-robin pointer ptr (highest-priority channel).
- load_en = rst_n & (~out_valid | out_ready): the output register can take a new word this cycle.
- Grant: scan channels ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first with in_valid=1 is granted. At most one grant bit is set; none if in_valid=0.
- in_ready = grant & {4{load_en}}, combinational. in_ready is independent of in_data, but a combinational path from out_ready and in_valid exists.
- On accept from channel g: out_data <= in_data_g, out_sel <= g, out_valid <= 1, ptr <= g+1 (mod 4; 3 wraps to 0).
- No accept and out_ready=1: out_valid <= 0; out_data and out_sel hold their last values.
- No accept and out_ready=0: output register holds unchanged.
- No accept: ptr holds.
- Sources: once in_valid[i] is raised it holds, with in_data_i stable, until the transfer. Downstream: out_valid/out_data/out_sel stay stable while out_valid=1 and out_ready=0.
- Simultaneous consume and accept in one cycle: the new word replaces the consumed one; out_valid stays 1 with no bubble.
- Fairness: a channel holding in_valid=1 waits at most 3 accepts by other channels before its own.

## Timing
- Reset (rst_n=0 at an edge): out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready=0 combinationally for the whole time rst_n=0.
- First cycle after reset: channel 0 has highest priority.
- Latency: a word accepted at edge N is on out_data with out_valid=1 after edge N, and can be consumed at edge N+1.
- Throughput: one word per cycle while out_ready=1 and any in_valid=1.
- Backpressure: with out_valid=1 and out_ready=0, in_ready=0 on all channels and no state changes.
- Reset mid-operation: any held output word is discarded, ptr returns to 0, and sources keep their pending valids.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with all in_valid=1 -> in_ready=0000 and out_valid=0, out_sel=00, out_data=0x00 throughout.
- Single channel: in_valid=0100, in_data2=0xA5, out_ready=1 -> in_ready=0100 for one cycle, then out_valid=1, out_data=0xA5, out_sel=10; in_valid dropped -> out_valid=0 next cycle.
- Round-robin with wrap: all four channels valid continuously with data 0x10/0x11/0x12/0x13, out_ready=1 -> out_sel sequence 00,01,10,11,00,01..., one word per cycle with no bubbles.
- Fairness with pointer: after channel 2 is accepted (ptr=3), raise in_valid=0101 -> channel 0 wins (scan 3,0), then channel 2; out_sel 00 then 10.
- Backpressure: out_valid=1 holding 0x33/sel 01, out_ready=0 for 4 cycles with in_valid=1111 -> in_ready=0000, out_data and out_sel stable; out_ready=1 -> same-cycle accept of the next channel (sel 10), out_valid stays 1.
- Mid-stream reset: during the continuous stream, pull rst_n low for one edge -> out_valid=0 and out_sel=00 next cycle; after release, the first word comes from channel 0.
